// File: rtl/datapath_pkg.sv
// datapath_pkg: state encodings and helpers shared by the multicycle datapath units
package datapath_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift in a dividend bit, trial-subtract the divisor)
module div_step
  import datapath_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] prem_i,
  input  logic                 bit_i,
  input  logic [DATAWIDTH-1:0] dvs_i,
  output logic [DATAWIDTH-1:0] prem_o,
  output logic                 q_o
);
  logic [DATAWIDTH:0] sh;
  logic [DATAWIDTH:0] diff;

  // The partial remainder is always below the divisor, so a W+1 bit difference
  // has its top bit set exactly when the trial subtraction borrows.
  always_comb begin
    sh     = {prem_i, bit_i};
    diff   = sh - {1'b0, dvs_i};
    q_o    = ~diff[DATAWIDTH];
    prem_o = q_o ? diff[DATAWIDTH-1:0] : sh[DATAWIDTH-1:0];
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multicycle unsigned restoring divider, one quotient bit per clock
module seq_divider
  import datapath_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 div_by_zero
);
  localparam int CW = clog2(DATAWIDTH + 1);

  logic                 state_q;
  logic [CW-1:0]        cnt_q;
  logic [DATAWIDTH-1:0] dvd_q;
  logic [DATAWIDTH-1:0] dvs_q;
  logic [DATAWIDTH-1:0] prem_q;
  logic [DATAWIDTH-1:0] quot_q;
  logic [DATAWIDTH-1:0] rem_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dbz_q;
  logic [DATAWIDTH-1:0] prem_d;
  logic [DATAWIDTH-1:0] dvd_d;
  logic                 qbit;

  div_step #(.DATAWIDTH(DATAWIDTH)) u_step (
    .prem_i(prem_q),
    .bit_i (dvd_q[DATAWIDTH-1]),
    .dvs_i (dvs_q),
    .prem_o(prem_d),
    .q_o   (qbit)
  );

  // The dividend register doubles as the quotient accumulator: bits shift out the top, quotient bits in at the bottom.
  always_comb dvd_d = {dvd_q[DATAWIDTH-2:0], qbit};

  // Handshake FSM; results are written only on a completing edge so the outputs never show partial values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (start && b == '0) begin
          quot_q <= '1;
          rem_q  <= a;
          dbz_q  <= 1'b1;
          done_q <= 1'b1;
        end else if (start) begin
          dvd_q   <= a;
          dvs_q   <= b;
          prem_q  <= '0;
          cnt_q   <= '0;
          dbz_q   <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= ST_RUN;
        end
      end else begin
        dvd_q  <= dvd_d;
        prem_q <= prem_d;
        cnt_q  <= cnt_q + CW'(1);
        if (cnt_q == CW'(DATAWIDTH - 1)) begin
          quot_q  <= dvd_d;
          rem_q   <= prem_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multicycle unsigned restoring divider, one quotient bit per clock.
- Sits directly upstream of the datapath pipeline register: quot/rem are captured by the REG stage on the cycle done is high.
- Replaces the single-cycle combinational DIV/MOD pair where clock period matters.
- start/busy/done handshake lets the scheduler issue one divide and wait.

Parameters:
- DATAWIDTH, 8, width of dividend, divisor, quotient and remainder; legal range 2..64.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only while busy=0.
- a  in  DATAWIDTH  unsigned dividend; sampled with start.
- b  in  DATAWIDTH  unsigned divisor; sampled with start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; quot/rem/div_by_zero valid and stable from this cycle until the next accepted start.
- quot  out  DATAWIDTH  quotient.
- rem  out  DATAWIDTH  remainder.
- div_by_zero  out  1  set with done when b was 0.

Behaviour:
- Reset (Rst_n low, asynchronous): state IDLE, busy=0, done=0, quot=0, rem=0, div_by_zero=0, counter=0, internal operand registers=0.
- FSM states: IDLE, RUN. Encoding comes from the package.
- IDLE with start=1 at edge k and b!=0:
  - Latch a into the shift register and b into the divisor register; clear partial remainder and count.
  - Go to RUN; busy=1 from edge k.
  - Clear div_by_zero.
- RUN, each edge:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract divisor from partial remainder, computed DATAWIDTH+1 bits wide so the borrow is visible.
  - No borrow: keep the difference and shift in quotient bit 1. Borrow: keep the shifted value and shift in 0.
  - Increment count.
- At edge k+DATAWIDTH, when count reaches DATAWIDTH-1 before that edge:
  - Register the final quot/rem.
  - done=1 and busy=0 from that edge. Return to IDLE.
  - Latency: done is visible exactly DATAWIDTH cycles after the start edge.
- done deasserts on the following edge unless a new divide by zero completes there.
- IDLE with start=1 and b==0:
  - No iteration.
  - At edge k: quot=all ones, rem=a, div_by_zero=1, done=1 (1-cycle latency). busy stays 0.
- start while busy=1: ignored. Operands are not resampled and the running divide is unaffected.
- start in the same cycle done=1: legal, since the FSM is IDLE. The new divide begins; outputs hold old results until its own done.
- quot/rem/div_by_zero update only on a completing edge. They never show intermediate values.
- Rst_n asserted mid-RUN: abort immediately to reset values. No done is generated for the aborted operation.
- Counter width is clog2(DATAWIDTH+1). The counter never wraps, because RUN exits at DATAWIDTH.

Decomposition:
- Shared package datapath_pkg:
  - state localparams ST_IDLE=1'b0, ST_RUN=1'b1;
  - a clog2 constant function reused by other multicycle units.
- One natural combinational sub-module, div_step (parameter DATAWIDTH):
  - inputs: partial remainder, next dividend bit, divisor;
  - outputs: new partial remainder, quotient bit.
- seq_divider holds the FSM, counter, operand registers and output registers.

Test Plan:
- W=8, reset, then start with a=100, b=7 -> busy high 8 cycles; done pulse at 8th edge after start; quot=14, rem=2, div_by_zero=0.
- a=255, b=1 -> quot=255, rem=0. Then a=3, b=10 -> quot=0, rem=3. Second start issued in the done cycle and accepted.
- a=5, b=0 -> done on the next edge; quot=8'hFF, rem=5, div_by_zero=1, busy never high.
- Mid-divide (a=200, b=9) pulse start with a=1, b=1 at cycle 3 -> ignored; result quot=22, rem=2 at cycle 8.
- Rst_n low asynchronously (between edges) at cycle 4 of a=50, b=3 -> all outputs 0 at once; no done ever; next divide a=50, b=3 gives quot=16, rem=2.
- Random a, b (b!=0) x1000 for W=8 and W=16 -> quot==a/b and rem==a%b; outputs stable between done pulses.
